// File: rtl/serial_arith_pkg.sv
// Shared types, mode encoding and sizing helpers for the serial arithmetic units.
package serial_arith_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Number of digits in a word; guarded so a bad DIGIT cannot divide by zero
  // before the elaboration check in the top reports it.
  function automatic int ndig_f(input int width, input int digit);
    return (digit > 0) ? (width / digit) : 1;
  endfunction

  function automatic int cnt_width_f(input int ndig);
    return (ndig > 1) ? $clog2(ndig) : 1;
  endfunction

endpackage

// File: rtl/serial_digit_adder.sv
// Combinational DIGIT-bit ripple adder exposing the carry into its MSB
// so the caller can derive two's-complement overflow.
module serial_digit_adder #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  logic [DIGIT:0] c;

  assign c[0] = cin;

  generate
    for (genvar gi = 0; gi < DIGIT; gi++) begin : g_fa
      assign s[gi]    = a[gi] ^ b[gi] ^ c[gi];
      assign c[gi+1]  = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
    end
  endgenerate

  assign cout     = c[DIGIT];
  assign c_msb_in = c[DIGIT-1];

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: LSB-first, DIGIT bits per cycle through one
// carry flip-flop; registered result, carry-out and signed overflow.
module serial_addsub
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int NDIG = ndig_f(WIDTH, DIGIT);
  localparam int CW   = cnt_width_f(NDIG);
  localparam logic [CW-1:0] LAST_CNT = CW'(NDIG - 1);

  generate
    if ((WIDTH < 2) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_param_check
      $fatal(1, "serial_addsub: WIDTH must be >= 2 and an integer multiple of DIGIT");
    end
  endgenerate

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic [WIDTH-1:0] res_reg, res_next;
  logic             carry_reg, carry_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             done_reg, done_next;
  logic [WIDTH-1:0] sum_reg, sum_next;
  logic             cout_reg, cout_next;
  logic             ovf_reg, ovf_next;

  logic [DIGIT-1:0] digit_sum;
  logic             digit_cout;
  logic             digit_cmsb;
  logic [WIDTH-1:0] res_shifted;

  serial_digit_adder #(
    .DIGIT (DIGIT)
  ) u_digit (
    .a        (a_reg[DIGIT-1:0]),
    .b        (b_reg[DIGIT-1:0]),
    .cin      (carry_reg),
    .s        (digit_sum),
    .cout     (digit_cout),
    .c_msb_in (digit_cmsb)
  );

  // New digit enters at the MSB end; the lowest digit of res_reg falls off.
  assign res_shifted = WIDTH'({digit_sum, res_reg} >> DIGIT);

  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    res_next   = res_reg;
    carry_next = carry_reg;
    cnt_next   = cnt_reg;
    done_next  = 1'b0;
    sum_next   = sum_reg;
    cout_next  = cout_reg;
    ovf_next   = ovf_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          a_next     = operand_a;
          // Subtraction as A + ~B + 1: invert B now, inject the +1 as carry-in.
          b_next     = (sub == MODE_ADD) ? operand_b : ~operand_b;
          carry_next = (sub == MODE_SUB);
          res_next   = '0;
          cnt_next   = '0;
          state_next = RUN;
        end
      end
      RUN: begin
        a_next     = a_reg >> DIGIT;
        b_next     = b_reg >> DIGIT;
        res_next   = res_shifted;
        carry_next = digit_cout;
        cnt_next   = cnt_reg + CW'(1);
        if (cnt_reg == LAST_CNT) begin
          sum_next   = res_shifted;
          cout_next  = digit_cout;
          ovf_next   = digit_cmsb ^ digit_cout;
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= '0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
      done_reg  <= 1'b0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      res_reg   <= res_next;
      carry_reg <= carry_next;
      cnt_reg   <= cnt_next;
      done_reg  <= done_next;
      sum_reg   <= sum_next;
      cout_reg  <= cout_next;
      ovf_reg   <= ovf_next;
    end
  end

  assign busy      = (state_reg == RUN);
  assign done      = done_reg;
  assign sum       = sum_reg;
  assign carry_out = cout_reg;
  assign overflow  = ovf_reg;

endmodule
